// File: rtl/stopwatch2uart.sv
// Snapshots hour/min/sec/centisecond on a send pulse and streams "HH:MM:SS.CC" to a UART TX.
// Define STOPWATCH2UART_CRLF_EN to append CR LF to every frame.
module stopwatch2uart (
    input  logic       clk,
    input  logic       reset,
    input  logic       send,
    input  logic [4:0] hour,
    input  logic [5:0] min,
    input  logic [5:0] sec,
    input  logic [6:0] msec,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] TIME_SEP = 8'h3A;
    localparam logic [7:0] FRAC_SEP = 8'h2E;
`ifdef STOPWATCH2UART_CRLF_EN
    localparam logic [3:0] LAST_IDX = 4'd12;
`else
    localparam logic [3:0] LAST_IDX = 4'd10;
`endif

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_HI,
        WAIT_LO,
        NEXT
    } state_t;

    state_t     r_state;
    logic [3:0] r_index;
    logic [4:0] r_hour;
    logic [5:0] r_min;
    logic [5:0] r_sec;
    logic [6:0] r_msec;
    logic [7:0] w_byte;

    function automatic logic [7:0] ascii_digit(input logic [6:0] v, input logic tens);
        logic [6:0] q;
        q = tens ? (v / 7'd10) : (v % 7'd10);
        return 8'h30 + {1'b0, q};
    endfunction

    always_comb begin
        w_byte = 8'h00;
        case (r_index)
            4'd0:  w_byte = ascii_digit({2'b00, r_hour}, 1'b1);
            4'd1:  w_byte = ascii_digit({2'b00, r_hour}, 1'b0);
            4'd2:  w_byte = TIME_SEP;
            4'd3:  w_byte = ascii_digit({1'b0, r_min}, 1'b1);
            4'd4:  w_byte = ascii_digit({1'b0, r_min}, 1'b0);
            4'd5:  w_byte = TIME_SEP;
            4'd6:  w_byte = ascii_digit({1'b0, r_sec}, 1'b1);
            4'd7:  w_byte = ascii_digit({1'b0, r_sec}, 1'b0);
            4'd8:  w_byte = FRAC_SEP;
            4'd9:  w_byte = ascii_digit(r_msec, 1'b1);
            4'd10: w_byte = ascii_digit(r_msec, 1'b0);
`ifdef STOPWATCH2UART_CRLF_EN
            4'd11: w_byte = 8'h0D;
            4'd12: w_byte = 8'h0A;
`endif
            default: w_byte = 8'h00;
        endcase
    end

    // Outputs are registered, so tx_start/busy appear one cycle after entering START.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_index  <= '0;
            r_hour   <= '0;
            r_min    <= '0;
            r_sec    <= '0;
            r_msec   <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            done     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (send) begin
                        r_hour  <= hour;
                        r_min   <= min;
                        r_sec   <= sec;
                        r_msec  <= (msec > 7'd99) ? 7'd99 : msec;
                        r_index <= '0;
                        r_state <= START;
                    end
                end
                START: begin
                    tx_start <= 1'b1;
                    tx_data  <= w_byte;
                    busy     <= 1'b1;
                    r_state  <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (tx_busy) r_state <= WAIT_LO;
                end
                WAIT_LO: begin
                    if (!tx_busy) r_state <= NEXT;
                end
                NEXT: begin
                    if (r_index == LAST_IDX) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_index <= r_index + 4'd1;
                        r_state <= START;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stopwatch2uart.sv
// Directed bench for stopwatch2uart with a simple UART TX busy model (10 cycles per byte).
module tb_stopwatch2uart;

`ifdef STOPWATCH2UART_CRLF_EN
    localparam int NB = 13;
`else
    localparam int NB = 11;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       send = 1'b0;
    logic [4:0] hour = '0;
    logic [5:0] min = '0;
    logic [5:0] sec = '0;
    logic [6:0] msec = '0;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       busy;
    logic       done;

    int n_assert = 0;
    int n_fail = 0;

    // TX model state and capture log
    int         busy_cnt = 0;
    int         n_start = 0;
    int         n_done = 0;
    logic [7:0] log_b [0:63];

    logic [7:0] exp_a [0:12] = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35, 8'h36,
                                 8'h2E, 8'h37, 8'h38, 8'h0D, 8'h0A};
    logic [7:0] exp_b [0:12] = '{8'h30, 8'h30, 8'h3A, 8'h30, 8'h35, 8'h3A, 8'h30, 8'h39,
                                 8'h2E, 8'h39, 8'h39, 8'h0D, 8'h0A};

    always #5 clk = ~clk;

    assign tx_busy = (busy_cnt != 0);

    always @(posedge clk) begin
        if (tx_start) begin
            log_b[n_start[5:0]] <= tx_data;
            n_start  <= n_start + 1;
            busy_cnt <= 10;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
        if (done) n_done <= n_done + 1;
    end

    stopwatch2uart dut (
        .clk(clk), .reset(reset), .send(send), .hour(hour), .min(min), .sec(sec),
        .msec(msec), .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
        .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic wait_starts(input string tag, input int target);
        int c = 0;
        while (n_start < target && c < 2000) begin
            @(negedge clk);
            c++;
        end
        check(tag, 32'(n_start >= target), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int c = 0;
        while (done !== 1'b1 && c < 2000) begin
            @(negedge clk);
            c++;
        end
        check(tag, {31'd0, done}, 32'd1);
        check({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic check_frame(input string tag, input int base, input logic [7:0] e [0:12]);
        for (int i = 0; i < NB; i++)
            check($sformatf("%s_b%0d", tag, i), {24'd0, log_b[base + i]}, {24'd0, e[i]});
    endtask

    initial begin
        int base;
        int d0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_tx_start", {31'd0, tx_start}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Frame A with latency, snapshot and busy-rejection checks
        hour = 5'd12; min = 6'd34; sec = 6'd56; msec = 7'd78;
        base = n_start;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        check("lat_busy_k", {31'd0, busy}, 32'd0);
        check("lat_start_k", {31'd0, tx_start}, 32'd0);
        @(negedge clk);
        check("lat_busy_k1", {31'd0, busy}, 32'd1);
        check("lat_start_k1", {31'd0, tx_start}, 32'd1);
        check("lat_data_k1", {24'd0, tx_data}, 32'h31);
        @(negedge clk);
        check("start_one_cycle", {31'd0, tx_start}, 32'd0);
        sec = 6'd57;
        wait_starts("wait_byte4", base + 5);
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        wait_done("frameA_done");
        check("frameA_count", n_start - base, NB);
        check_frame("frameA", base, exp_a);

        // Send in the done cycle: accepted, leading zeros and clamp
        hour = 5'd0; min = 6'd5; sec = 6'd9; msec = 7'd120;
        d0 = n_done;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        check("one_done_pulse", n_done - d0, 1);
        base = n_start;
        @(negedge clk);
        check("after_done_busy", {31'd0, busy}, 32'd1);
        check("after_done_start", {31'd0, tx_start}, 32'd1);
        wait_done("frameB_done");
        check("frameB_count", n_start - base, NB);
        check_frame("frameB", base, exp_b);

        // Reset during byte 6 WAIT_LO
        repeat (3) @(negedge clk);
        hour = 5'd12; min = 6'd34; sec = 6'd56; msec = 7'd78;
        base = n_start;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        wait_starts("wait_byte6", base + 7);
        repeat (2) @(negedge clk);
        check("pre_rst_tx_busy", {31'd0, tx_busy}, 32'd1);
        d0 = n_done;
        reset = 1'b1;
        #1;
        check("mid_rst_start", {31'd0, tx_start}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_data", {24'd0, tx_data}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("abandon_no_bytes", n_start - base, 7);
        check("abandon_no_done", n_done - d0, 0);

        // Restart from byte 0
        base = n_start;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        wait_done("frameC_done");
        check("frameC_count", n_start - base, NB);
        check_frame("frameC", base, exp_a);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
